// File: rtl/block_interleaver_if.sv
// Coded-bit stream, read request and status bundle between the puncturer side,
// the interleaver and the mapper side.
interface block_interleaver_if;
  logic       bitIn;
  logic       we;
  logic [3:0] rate;
  logic       re;
  logic       inReady;
  logic       bitOut;
  logic       outValid;
  logic       overflow;

  // Upstream/downstream agent: drives bits, rate and read requests.
  modport master (
    output bitIn, we, rate, re,
    input  inReady, bitOut, outValid, overflow
  );

  // Interleaver side.
  modport slave (
    input  bitIn, we, rate, re,
    output inReady, bitOut, outValid, overflow
  );
endinterface

// File: rtl/block_interleaver.sv
// Bit-serial 802.11a block interleaver with two ping-pong symbol banks.
// Each bit is written at its permuted address, so reading is purely sequential.
module block_interleaver (
  input  logic               clk,
  input  logic               reset,
  block_interleaver_if.slave bus
);

  localparam int unsigned MAX_BITS = 288;

  // Size code: 0 -> 48 bits, 1 -> 96, 2 -> 192 (s=2), 3 -> 288 (s=3).
  function automatic logic [1:0] rate_code(input logic [3:0] r);
    case (r)
      4'b0101, 4'b0111: rate_code = 2'd1;
      4'b1001, 4'b1011: rate_code = 2'd2;
      4'b0001, 4'b0011: rate_code = 2'd3;
      default:          rate_code = 2'd0;
    endcase
  endfunction

  function automatic logic [8:0] code_last(input logic [1:0] c);
    case (c)
      2'd1:    code_last = 9'd95;
      2'd2:    code_last = 9'd191;
      2'd3:    code_last = 9'd287;
      default: code_last = 9'd47;
    endcase
  endfunction

  // Residue mod 3 by MSB-first Horner accumulation (no divider).
  function automatic logic [1:0] mod3(input logic [8:0] v);
    logic [2:0] acc;
    acc = 3'd0;
    for (int b = 8; b >= 0; b--) begin
      acc = {acc[1:0], 1'b0} + {2'b00, v[b]};
      if (acc >= 3'd3) acc = acc - 3'd3;
    end
    mod3 = acc[1:0];
  endfunction

  logic             r_wptr;
  logic             r_rptr;
  logic [8:0]       r_wk;
  logic [8:0]       r_rd_addr;
  logic             r_full [2];
  logic [1:0]       r_code [2];
  logic             r_bit_out;
  logic             r_out_valid;
  logic             r_overflow;
  logic             r_mem  [2][MAX_BITS];

  logic             w_wr_acc;
  logic             w_wr_last;
  logic             w_rd_go;
  logic             w_rd_last;
  logic [1:0]       w_wcode;
  logic [3:0]       w_col;
  logic [4:0]       w_row;
  logic [8:0]       w_col3;
  logic [8:0]       w_base;
  logic [8:0]       w_i;
  logic [1:0]       w_im3;
  logic [1:0]       w_cm3;
  logic [1:0]       w_d;
  logic [8:0]       w_j;

  assign bus.inReady  = ~r_full[r_wptr];
  assign bus.bitOut   = r_bit_out;
  assign bus.outValid = r_out_valid;
  assign bus.overflow = r_overflow;

  // The first bit of a symbol uses the live rate; later bits use the bank's latched size.
  assign w_wcode   = (r_wk == 9'd0) ? rate_code(bus.rate) : r_code[r_wptr];
  assign w_wr_acc  = bus.we & ~r_full[r_wptr];
  assign w_wr_last = w_wr_acc && (r_wk == code_last(w_wcode));
  assign w_rd_go   = bus.re & r_full[r_rptr];
  assign w_rd_last = w_rd_go && (r_rd_addr == code_last(r_code[r_rptr]));

  assign w_col  = r_wk[3:0];
  assign w_row  = r_wk[8:4];
  assign w_col3 = {4'd0, w_col, 1'b0} + {5'd0, w_col};
  assign w_i    = w_base + {4'd0, w_row};
  assign w_im3  = mod3(w_i);
  assign w_cm3  = mod3({5'd0, w_col});
  assign w_d    = (w_im3 >= w_cm3) ? (w_im3 - w_cm3) : (w_im3 + 2'd3 - w_cm3);

  // Permuted write address: first step (column-major spread), then the s-rotation.
  always_comb begin
    w_base = w_col3;
    w_j    = w_i;
    case (w_wcode)
      2'd1: w_base = {w_col3[7:0], 1'b0};
      2'd2: w_base = {w_col3[6:0], 2'b00};
      2'd3: w_base = {1'b0, w_col, 4'd0} + {4'd0, w_col, 1'b0};
      default: w_base = w_col3;
    endcase
    case (w_wcode)
      2'd2: w_j = {w_i[8:1], w_i[0] ^ w_col[0]};
      2'd3: w_j = w_i - {7'd0, w_im3} + {7'd0, w_d};
      default: w_j = w_i;
    endcase
  end

  // Symbol storage; contents need no reset because the full flags gate every read.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr][w_j] <= bus.bitIn;
  end

  // Per-bank full flag and latched size; set and clear only ever target different banks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        r_full[b] <= 1'b0;
        r_code[b] <= 2'd0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_wr_acc && (r_wptr == 1'(b)) && (r_wk == 9'd0)) r_code[b] <= w_wcode;
        if (w_wr_last && (r_wptr == 1'(b)))      r_full[b] <= 1'b1;
        else if (w_rd_last && (r_rptr == 1'(b))) r_full[b] <= 1'b0;
      end
    end
  end

  // Write counter, write pointer and sticky overflow on writes into a full bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wk       <= 9'd0;
      r_wptr     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        if (w_wr_last) begin
          r_wk   <= 9'd0;
          r_wptr <= ~r_wptr;
        end else begin
          r_wk <= r_wk + 9'd1;
        end
      end
      if (bus.we && r_full[r_wptr]) r_overflow <= 1'b1;
    end
  end

  // Sequential read of the full bank, one registered bit per requested cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_addr   <= 9'd0;
      r_rptr      <= 1'b0;
      r_bit_out   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_rd_go;
      if (w_rd_go) begin
        r_bit_out <= r_mem[r_rptr][r_rd_addr];
        if (w_rd_last) begin
          r_rd_addr <= 9'd0;
          r_rptr    <= ~r_rptr;
        end else begin
          r_rd_addr <= r_rd_addr + 9'd1;
        end
      end
    end
  end

endmodule
